// File: rtl/lc3_irq_pkg.sv
// Shared types and default widths for the LC-3 external-interrupt controller.
package lc3_irq_pkg;

    localparam int unsigned NUM_CH_MAX = 16;
    localparam int unsigned DEF_NUM_CH = 8;
    localparam int unsigned DEF_PRIO_W = 3;
    localparam int unsigned DEF_VEC_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    // Width of a channel index; at least one bit even for a single channel.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lc3_irq_if.sv
// Peripheral/core-facing signal bundle of the interrupt controller.
interface lc3_irq_if
    import lc3_irq_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned PRIO_W = DEF_PRIO_W,
    parameter int unsigned VEC_W  = DEF_VEC_W
);
    logic [NUM_CH-1:0]        irq_req;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*PRIO_W-1:0] ch_prio;
    logic [NUM_CH*VEC_W-1:0]  ch_vec;
    logic [PRIO_W-1:0]        cpu_pl;
    logic                     int_ack;
    logic                     IRQ;
    logic [VEC_W-1:0]         INTV;
    logic [PRIO_W-1:0]        INTP;
    logic [NUM_CH-1:0]        ack_ch;
    logic [NUM_CH-1:0]        pending;

    // Controller side
    modport master (
        input  irq_req, ch_en, ch_prio, ch_vec, cpu_pl, int_ack,
        output IRQ, INTV, INTP, ack_ch, pending
    );

    // Core / peripheral side
    modport slave (
        output irq_req, ch_en, ch_prio, ch_vec, cpu_pl, int_ack,
        input  IRQ, INTV, INTP, ack_ch, pending
    );
endinterface

// File: rtl/lc3_irq_pick.sv
// Combinational winner selection: highest priority, ties to lowest index.
module lc3_irq_pick
    import lc3_irq_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned PRIO_W = DEF_PRIO_W,
    parameter int unsigned VEC_W  = DEF_VEC_W,
    parameter int unsigned IDX_W  = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0]        eligible,
    input  logic [NUM_CH*PRIO_W-1:0] ch_prio,
    input  logic [NUM_CH*VEC_W-1:0]  ch_vec,
    output logic                     valid_c,
    output logic [IDX_W-1:0]         idx_c,
    output logic [VEC_W-1:0]         vec_c,
    output logic [PRIO_W-1:0]        prio_c
);

    // Linear scan; strict compare keeps the lowest index on ties.
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        vec_c   = '0;
        prio_c  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (eligible[i] && (!valid_c || (ch_prio[i*PRIO_W +: PRIO_W] > prio_c))) begin
                valid_c = 1'b1;
                idx_c   = IDX_W'(i);
                vec_c   = ch_vec[i*VEC_W +: VEC_W];
                prio_c  = ch_prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/lc3_irq_ctrl.sv
// LC-3 external-interrupt controller: captures per-channel requests,
// arbitrates against the core priority level and presents one IRQ/INTV/INTP
// until acknowledged. Define LC3_IRQ_LEVEL_EN for level-sensitive requests
// (pending = irq_req & ch_en, no edge capture).
module lc3_irq_ctrl
    import lc3_irq_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned PRIO_W = DEF_PRIO_W,
    parameter int unsigned VEC_W  = DEF_VEC_W
) (
    input  logic      clk,
    input  logic      rst,
    lc3_irq_if.master bus
);

    localparam int unsigned IDX_W = idx_w(NUM_CH);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [VEC_W-1:0]    intv_q, intv_d;
    logic [PRIO_W-1:0]   intp_q, intp_d;
    logic                irq_q, irq_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;

    logic [NUM_CH-1:0]   eligible_c;
    logic                win_ok_c;
    logic                ack_take_c;
    logic                pick_valid_c;
    logic [IDX_W-1:0]    pick_idx_c;
    logic [VEC_W-1:0]    pick_vec_c;
    logic [PRIO_W-1:0]   pick_prio_c;

`ifndef LC3_IRQ_LEVEL_EN
    logic [NUM_CH-1:0]   prev_q;

    // Previous request sample for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= '0;
        else      prev_q <= bus.irq_req;
    end
`endif

    // Channels allowed to interrupt at the current processor level
    always_comb begin
        eligible_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            eligible_c[i] = pend_q[i] & bus.ch_en[i]
                          & (bus.ch_prio[i*PRIO_W +: PRIO_W] > bus.cpu_pl);
        end
    end

    lc3_irq_pick #(
        .NUM_CH (NUM_CH),
        .PRIO_W (PRIO_W),
        .VEC_W  (VEC_W),
        .IDX_W  (IDX_W)
    ) u_pick (
        .eligible (eligible_c),
        .ch_prio  (bus.ch_prio),
        .ch_vec   (bus.ch_vec),
        .valid_c  (pick_valid_c),
        .idx_c    (pick_idx_c),
        .vec_c    (pick_vec_c),
        .prio_c   (pick_prio_c)
    );

    // Presented channel still wants service; ack is only honoured in REQ
    always_comb begin
        win_ok_c   = pend_q[win_q] & bus.ch_en[win_q] & (intp_q > bus.cpu_pl);
        ack_take_c = (state_q == REQ) & bus.int_ack;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state: grant, hold until ack or withdrawal, one-cycle holdoff
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid_c) state_d = REQ;
            REQ: begin
                if (bus.int_ack)    state_d = HOLDOFF;
                else if (!win_ok_c) state_d = IDLE;
            end
            HOLDOFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: latch winner on grant, ack pulse, pending update
    always_comb begin
        win_d  = win_q;
        intv_d = intv_q;
        intp_d = intp_q;
        ack_d  = '0;
        irq_d  = (state_d == REQ);
        if ((state_q == IDLE) && pick_valid_c) begin
            win_d  = pick_idx_c;
            intv_d = pick_vec_c;
            intp_d = pick_prio_c;
        end
        if (ack_take_c) ack_d = NUM_CH'(1) << win_q;
`ifdef LC3_IRQ_LEVEL_EN
        pend_d = bus.irq_req & bus.ch_en;
`else
        // A new edge in the ack cycle wins over the clear
        pend_d = (pend_q & ~ack_d) | (bus.irq_req & ~prev_q);
`endif
    end

    // Output and capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            win_q  <= '0;
            intv_q <= '0;
            intp_q <= '0;
            irq_q  <= 1'b0;
            ack_q  <= '0;
        end else begin
            pend_q <= pend_d;
            win_q  <= win_d;
            intv_q <= intv_d;
            intp_q <= intp_d;
            irq_q  <= irq_d;
            ack_q  <= ack_d;
        end
    end

    assign bus.IRQ     = irq_q;
    assign bus.INTV    = intv_q;
    assign bus.INTP    = intp_q;
    assign bus.ack_ch  = ack_q;
    assign bus.pending = pend_q;

endmodule

// File: tb/tb_lc3_irq_ctrl.sv
// Self-checking bench for lc3_irq_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_lc3_irq_ctrl;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned PRIO_W = 3;
    localparam int unsigned VEC_W  = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    lc3_irq_if #(.NUM_CH(NUM_CH), .PRIO_W(PRIO_W), .VEC_W(VEC_W)) bus ();

    lc3_irq_ctrl #(.NUM_CH(NUM_CH), .PRIO_W(PRIO_W), .VEC_W(VEC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit [7:0] m_pend, m_prev, m_ack, m_np, m_a;
    bit       m_irq, m_hold;
    int       m_ch, m_best, m_bp, m_p;
    bit [7:0] m_vec;
    bit [2:0] m_prio;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = '0; m_prev = '0; m_ack = '0; m_irq = 0; m_hold = 0;
            m_ch = 0; m_vec = '0; m_prio = '0;
        end else begin
            m_best = -1; m_bp = -1;
            for (int i = 0; i < 8; i++) begin
                m_p = int'(bus.ch_prio[i*3 +: 3]);
                if (m_pend[i] && bus.ch_en[i] && m_p > int'(bus.cpu_pl) && m_p > m_bp) begin
                    m_best = i; m_bp = m_p;
                end
            end
            m_np = m_pend; m_a = '0;
            if (m_irq && bus.int_ack) begin m_np[m_ch] = 0; m_a[m_ch] = 1; end
`ifdef LC3_IRQ_LEVEL_EN
            m_np = bus.irq_req & bus.ch_en;
`else
            m_np = m_np | (bus.irq_req & ~m_prev);
`endif
            m_prev = bus.irq_req;
            if (m_irq) begin
                if (bus.int_ack) begin m_irq = 0; m_hold = 1; end
                else if (!(m_pend[m_ch] && bus.ch_en[m_ch] && m_prio > bus.cpu_pl)) m_irq = 0;
            end else if (m_hold) begin
                m_hold = 0;
            end else if (m_best >= 0) begin
                m_irq = 1; m_ch = m_best;
                m_vec = bus.ch_vec[m_best*8 +: 8]; m_prio = 3'(m_bp);
            end
            m_pend = m_np; m_ack = m_a;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input int p, input int v);
        bus.ch_prio[i*PRIO_W +: PRIO_W] = PRIO_W'(p);
        bus.ch_vec[i*VEC_W +: VEC_W]    = VEC_W'(v);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.irq_req = '0; bus.ch_en = '1; bus.ch_prio = '0; bus.ch_vec = '0;
        bus.cpu_pl = '0; bus.int_ack = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        bus.irq_req = '1; bus.int_ack = 1'b1;
        tick(); tick();
        checks++;
        if ({bus.IRQ, bus.INTV, bus.INTP, bus.ack_ch, bus.pending} !== 28'h0) begin
            failures++;
            $display("FAIL reset_state got irq=%0b intv=%h intp=%0d ack=%h pend=%h exp all zero",
                     bus.IRQ, bus.INTV, bus.INTP, bus.ack_ch, bus.pending);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        set_ch(2, 4, 'h82);
        bus.irq_req[2] = 1'b1;
        tick();
        checks++;
        if ({bus.IRQ, bus.pending} !== {1'b0, 8'h04}) begin
            failures++;
            $display("FAIL basic_pend got irq=%0b pend=%h exp irq=0 pend=04", bus.IRQ, bus.pending);
        end
        tick();
        checks++;
        if ({bus.IRQ, bus.INTV, bus.INTP} !== {1'b1, 8'h82, 3'd4}) begin
            failures++;
            $display("FAIL basic_irq got irq=%0b intv=%h intp=%0d exp 1/82/4", bus.IRQ, bus.INTV, bus.INTP);
        end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        checks++;
        if ({bus.IRQ, bus.ack_ch, bus.pending} !== {1'b0, 8'h04, 8'h00}) begin
            failures++;
            $display("FAIL basic_ack got irq=%0b ack=%h pend=%h exp 0/04/00", bus.IRQ, bus.ack_ch, bus.pending);
        end
        tick();
        checks++;
        if (bus.ack_ch !== 8'h00) begin
            failures++;
            $display("FAIL basic_ack_pulse got ack=%h exp 00", bus.ack_ch);
        end
    endtask

    task automatic test_tie();
        do_reset();
        set_ch(1, 5, 'h61);
        set_ch(6, 5, 'h66);
        bus.irq_req = 8'h42;
        tick(); tick();
        checks++;
        if ({bus.IRQ, bus.INTV, bus.INTP} !== {1'b1, 8'h61, 3'd5}) begin
            failures++;
            $display("FAIL tie_first got irq=%0b intv=%h intp=%0d exp 1/61/5", bus.IRQ, bus.INTV, bus.INTP);
        end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        checks++;
        if ({bus.IRQ, bus.ack_ch, bus.pending} !== {1'b0, 8'h02, 8'h40}) begin
            failures++;
            $display("FAIL tie_ack got irq=%0b ack=%h pend=%h exp 0/02/40", bus.IRQ, bus.ack_ch, bus.pending);
        end
        tick();
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL tie_holdoff got irq=%0b exp 0", bus.IRQ);
        end
        tick();
        checks++;
        if ({bus.IRQ, bus.INTV, bus.INTP} !== {1'b1, 8'h66, 3'd5}) begin
            failures++;
            $display("FAIL tie_second got irq=%0b intv=%h intp=%0d exp 1/66/5", bus.IRQ, bus.INTV, bus.INTP);
        end
    endtask

    task automatic test_cpu_pl();
        do_reset();
        set_ch(3, 2, 'h33);
        bus.cpu_pl = 3'd2;
        bus.irq_req[3] = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({bus.IRQ, bus.pending} !== {1'b0, 8'h08}) begin
            failures++;
            $display("FAIL pl_block got irq=%0b pend=%h exp 0/08", bus.IRQ, bus.pending);
        end
        bus.cpu_pl = 3'd1;
        tick();
        checks++;
        if ({bus.IRQ, bus.INTV, bus.INTP} !== {1'b1, 8'h33, 3'd2}) begin
            failures++;
            $display("FAIL pl_lower got irq=%0b intv=%h intp=%0d exp 1/33/2", bus.IRQ, bus.INTV, bus.INTP);
        end
    endtask

    task automatic test_drop();
        do_reset();
        set_ch(0, 3, 'h30);
        bus.irq_req[0] = 1'b1;
        tick(); tick();
        bus.cpu_pl = 3'd3;
        tick();
        checks++;
        if ({bus.IRQ, bus.pending} !== {1'b0, 8'h01}) begin
            failures++;
            $display("FAIL drop_pl got irq=%0b pend=%h exp 0/01", bus.IRQ, bus.pending);
        end
        bus.cpu_pl = 3'd0;
        tick();
        checks++;
        if ({bus.IRQ, bus.INTV, bus.INTP} !== {1'b1, 8'h30, 3'd3}) begin
            failures++;
            $display("FAIL drop_rearm got irq=%0b intv=%h intp=%0d exp 1/30/3", bus.IRQ, bus.INTV, bus.INTP);
        end
    endtask

    task automatic test_no_rearb();
        do_reset();
        set_ch(4, 1, 'h44);
        set_ch(7, 7, 'h77);
        bus.irq_req[4] = 1'b1;
        tick(); tick();
        bus.irq_req[7] = 1'b1;
        tick(); tick();
        checks++;
        if ({bus.IRQ, bus.INTV, bus.INTP, bus.pending} !== {1'b1, 8'h44, 3'd1, 8'h90}) begin
            failures++;
            $display("FAIL norearb_hold got irq=%0b intv=%h intp=%0d pend=%h exp 1/44/1/90",
                     bus.IRQ, bus.INTV, bus.INTP, bus.pending);
        end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        checks++;
        if ({bus.IRQ, bus.ack_ch} !== {1'b0, 8'h10}) begin
            failures++;
            $display("FAIL norearb_ack got irq=%0b ack=%h exp 0/10", bus.IRQ, bus.ack_ch);
        end
        tick(); tick();
        checks++;
        if ({bus.IRQ, bus.INTV, bus.INTP} !== {1'b1, 8'h77, 3'd7}) begin
            failures++;
            $display("FAIL norearb_next got irq=%0b intv=%h intp=%0d exp 1/77/7", bus.IRQ, bus.INTV, bus.INTP);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        set_ch(5, 6, 'h55);
        bus.irq_req[5] = 1'b1;
        tick(); tick();
        bus.irq_req[5] = 1'b0;
        tick();
        bus.irq_req[5] = 1'b1;
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        checks++;
        if ({bus.IRQ, bus.ack_ch, bus.pending} !== {1'b0, 8'h20, 8'h20}) begin
            failures++;
            $display("FAIL setwins_ack got irq=%0b ack=%h pend=%h exp 0/20/20", bus.IRQ, bus.ack_ch, bus.pending);
        end
        tick(); tick();
        checks++;
        if ({bus.IRQ, bus.INTV, bus.INTP} !== {1'b1, 8'h55, 3'd6}) begin
            failures++;
            $display("FAIL setwins_again got irq=%0b intv=%h intp=%0d exp 1/55/6", bus.IRQ, bus.INTV, bus.INTP);
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        set_ch(2, 5, 'h22);
        set_ch(3, 1, 'h23);
        bus.irq_req = 8'h0C;
        tick(); tick();
        rst = 1'b0;
        #2;
        checks++;
        if ({bus.IRQ, bus.pending} !== {1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_mid_req got irq=%0b pend=%h exp 0/00", bus.IRQ, bus.pending);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_random();
        int nprint;
        nprint = 0;
        do_reset();
        for (int i = 0; i < 8; i++) set_ch(i, int'($urandom_range(0, 7)), int'($urandom));
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.irq_req ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.ch_en = ~(8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 7) == 0) bus.cpu_pl = 3'($urandom_range(0, 5));
            if ($urandom_range(0, 31) == 0)
                set_ch(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom));
            bus.int_ack = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if ({bus.IRQ, bus.INTV, bus.INTP, bus.ack_ch, bus.pending} !==
                {m_irq, m_vec, m_prio, m_ack, m_pend}) begin
                failures++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL random cyc=%0d got irq=%0b intv=%h intp=%0d ack=%h pend=%h exp irq=%0b intv=%h intp=%0d ack=%h pend=%h",
                             cyc, bus.IRQ, bus.INTV, bus.INTP, bus.ack_ch, bus.pending,
                             m_irq, m_vec, m_prio, m_ack, m_pend);
                end
            end
        end
        bus.int_ack = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.irq_req = '0; bus.ch_en = '0; bus.ch_prio = '0; bus.ch_vec = '0;
        bus.cpu_pl = '0; bus.int_ack = 1'b0;
        test_reset();
        test_basic();
        test_tie();
        test_cpu_pl();
        test_drop();
        test_no_rearb();
        test_set_wins();
        test_reset_mid_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
